// File: rtl/buffer_ring_manager.sv
// Ownership bookkeeping for a ring of equal DDR frame buffers shared by one producer and one consumer.
// Supports latest-frame (N-way buffering) and in-order queue with drop-oldest overflow.
module buffer_ring_manager #(
    parameter int MM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BUFFER_COUNT  = 4,
    parameter int IDX_WIDTH     = 3
) (
    input  logic                     SYS_aclk,
    input  logic                     SYS_areset,
    input  logic [MM_ADDR_WIDTH-1:0] BRM_base_address,
    input  logic [4:0]               BRM_log_length,
    input  logic                     BRM_mode,
    input  logic                     BRM_write_beat,
    input  logic                     BRM_request,
    output logic [MM_ADDR_WIDTH-1:0] BRM_write_address,
    output logic [MM_ADDR_WIDTH-1:0] BRM_read_buffer,
    output logic                     BRM_grant,
    output logic                     BRM_empty,
    output logic [31:0]              BRM_frame_count,
    output logic [15:0]              BRM_drop_count
);

    localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int CNT_WIDTH  = $clog2(BUFFER_COUNT + 1);
    localparam logic [MM_ADDR_WIDTH-1:0] ADDR_ONE = 1;

    typedef enum logic [1:0] {
        BUF_FREE    = 2'd0,
        BUF_WRITING = 2'd1,
        BUF_READY   = 2'd2,
        BUF_READING = 2'd3
    } buf_state_t;

    buf_state_t           st_q   [BUFFER_COUNT];
    buf_state_t           st_d   [BUFFER_COUNT];
    logic [IDX_WIDTH-1:0] fifo_q [BUFFER_COUNT];
    logic [IDX_WIDTH-1:0] fifo_d [BUFFER_COUNT];
    logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic [IDX_WIDTH-1:0] widx_q, widx_d;
    logic [IDX_WIDTH-1:0] ridx_q, ridx_d;
    logic [21:0]          beat_q, beat_d;
    logic [4:0]           log_len_q, log_len_d;
    logic [31:0]          frame_d;
    logic [16:0]          drop_sum;
    logic [15:0]          drop_d;
    logic                 req_q;
    logic                 grant_d;
    logic                 free_found;
    logic [IDX_WIDTH-1:0] free_idx;
    logic [22:0]          len_m1;
    logic                 last_beat;
    logic [MM_ADDR_WIDTH-1:0] wa_d, rb_d, wa_rst;

    assign len_m1    = (23'd1 << log_len_q) - 23'd1;
    assign last_beat = ({1'b0, beat_q} == len_m1);

    // The claim acts first on the FIFO as it stood at the start of the cycle;
    // the completion then sees the buffer that claim released as FREE.
    always_comb begin
        st_d       = st_q;
        fifo_d     = fifo_q;
        fcnt_d     = fcnt_q;
        widx_d     = widx_q;
        ridx_d     = ridx_q;
        beat_d     = beat_q;
        log_len_d  = log_len_q;
        frame_d    = BRM_frame_count;
        drop_sum   = {1'b0, BRM_drop_count};
        grant_d    = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;

        if (BRM_request && !req_q && fcnt_q != '0) begin
            grant_d = 1'b1;
            ridx_d  = fifo_q[0];
            for (int i = 0; i < BUFFER_COUNT; i++) begin
                if (IDX_WIDTH'(i) == ridx_q)    st_d[i] = BUF_FREE;
                if (IDX_WIDTH'(i) == fifo_q[0]) st_d[i] = BUF_READING;
            end
            for (int i = 0; i < BUFFER_COUNT - 1; i++) fifo_d[i] = fifo_d[i + 1];
            fcnt_d = fcnt_d - 1'b1;
        end

        if (BRM_write_beat) begin
            if (last_beat) begin
                beat_d    = '0;
                log_len_d = BRM_log_length;
                frame_d   = BRM_frame_count + 32'd1;
                if (!BRM_mode) begin
                    for (int i = 0; i < BUFFER_COUNT; i++)
                        if (st_d[i] == BUF_READY) st_d[i] = BUF_FREE;
                    drop_sum = drop_sum + 17'(fcnt_d);
                    fcnt_d   = '0;
                end
                for (int j = 0; j < BUFFER_COUNT; j++)
                    if (CNT_WIDTH'(j) == fcnt_d) fifo_d[j] = widx_q;
                for (int i = 0; i < BUFFER_COUNT; i++)
                    if (IDX_WIDTH'(i) == widx_q) st_d[i] = BUF_READY;
                fcnt_d = fcnt_d + 1'b1;
                for (int i = BUFFER_COUNT - 1; i >= 0; i--) begin
                    if (st_d[i] == BUF_FREE) begin
                        free_found = 1'b1;
                        free_idx   = IDX_WIDTH'(i);
                    end
                end
                if (free_found) begin
                    widx_d = free_idx;
                end else begin
                    widx_d = fifo_d[0];
                    for (int i = 0; i < BUFFER_COUNT - 1; i++) fifo_d[i] = fifo_d[i + 1];
                    fcnt_d   = fcnt_d - 1'b1;
                    drop_sum = drop_sum + 17'd1;
                end
                for (int i = 0; i < BUFFER_COUNT; i++)
                    if (IDX_WIDTH'(i) == widx_d) st_d[i] = BUF_WRITING;
            end else begin
                beat_d = beat_q + 22'd1;
            end
        end

        drop_d = (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
    end

    assign wa_d = BRM_base_address
                + (MM_ADDR_WIDTH'(widx_d) << (6'(log_len_d) + 6'(BEAT_SHIFT)))
                + (MM_ADDR_WIDTH'(beat_d) << BEAT_SHIFT);
    assign rb_d = BRM_base_address
                + (MM_ADDR_WIDTH'(ridx_d) << (6'(log_len_d) + 6'(BEAT_SHIFT)));
    assign wa_rst = BRM_base_address
                  + (ADDR_ONE << (6'(BRM_log_length) + 6'(BEAT_SHIFT)));

    always_ff @(posedge SYS_aclk) begin
        if (SYS_areset) begin
            for (int i = 0; i < BUFFER_COUNT; i++) begin
                st_q[i]   <= (i == 0) ? BUF_READING : ((i == 1) ? BUF_WRITING : BUF_FREE);
                fifo_q[i] <= '0;
            end
            fcnt_q            <= '0;
            widx_q            <= IDX_WIDTH'(1);
            ridx_q            <= '0;
            beat_q            <= '0;
            log_len_q         <= BRM_log_length;
            req_q             <= 1'b0;
            BRM_write_address <= wa_rst;
            BRM_read_buffer   <= BRM_base_address;
            BRM_grant         <= 1'b0;
            BRM_empty         <= 1'b1;
            BRM_frame_count   <= '0;
            BRM_drop_count    <= '0;
        end else begin
            st_q              <= st_d;
            fifo_q            <= fifo_d;
            fcnt_q            <= fcnt_d;
            widx_q            <= widx_d;
            ridx_q            <= ridx_d;
            beat_q            <= beat_d;
            log_len_q         <= log_len_d;
            req_q             <= BRM_request;
            BRM_write_address <= wa_d;
            BRM_read_buffer   <= rb_d;
            BRM_grant         <= grant_d;
            BRM_empty         <= (fcnt_d == '0);
            BRM_frame_count   <= frame_d;
            BRM_drop_count    <= drop_d;
        end
    end

endmodule

// File: tb/tb_buffer_ring_manager.sv
// Bench for buffer_ring_manager: fixed vector table, hand-written corner sequences and
// random traffic, all compared against a queue-based model of the buffer ring.
module tb_buffer_ring_manager;

    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic [31:0] base;
    logic [4:0]  log_len;
    logic        mode;
    logic        beat;
    logic        req;
    logic [31:0] wa;
    logic [31:0] rb;
    logic        grant;
    logic        empty;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;

    buffer_ring_manager dut (
        .SYS_aclk          (clk),
        .SYS_areset        (rst),
        .BRM_base_address  (base),
        .BRM_log_length    (log_len),
        .BRM_mode          (mode),
        .BRM_write_beat    (beat),
        .BRM_request       (req),
        .BRM_write_address (wa),
        .BRM_read_buffer   (rb),
        .BRM_grant         (grant),
        .BRM_empty         (empty),
        .BRM_frame_count   (frame_cnt),
        .BRM_drop_count    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // reference model: buffer indices, a FIFO queue of READY buffers, counters
    int          m_r, m_w, m_cnt, m_ll, m_drop;
    int unsigned m_frame;
    bit          m_grant, m_req_prev;
    int          m_fifo[$];

    function automatic int lowest_free();
        for (int i = 0; i < N; i++) begin
            bit used = (i == m_r);
            foreach (m_fifo[k]) if (m_fifo[k] == i) used = 1'b1;
            if (!used) return i;
        end
        return -1;
    endfunction

    task automatic model_update();
        bit rise;
        int nf;
        if (rst) begin
            m_r = 0; m_w = 1; m_fifo.delete(); m_cnt = 0; m_frame = 0; m_drop = 0;
            m_ll = int'(log_len); m_grant = 1'b0; m_req_prev = 1'b0;
        end else begin
            rise = req && !m_req_prev;
            m_req_prev = req;
            m_grant = 1'b0;
            if (rise && m_fifo.size() > 0) begin
                m_r = m_fifo.pop_front();
                m_grant = 1'b1;
            end
            if (beat) begin
                m_cnt++;
                if (m_cnt == (1 << m_ll)) begin
                    m_cnt = 0;
                    m_ll = int'(log_len);
                    m_frame++;
                    if (!mode) begin
                        m_drop += m_fifo.size();
                        m_fifo.delete();
                    end
                    m_fifo.push_back(m_w);
                    nf = lowest_free();
                    if (nf >= 0) m_w = nf;
                    else begin
                        m_w = m_fifo.pop_front();
                        m_drop++;
                    end
                    if (m_drop > 65535) m_drop = 65535;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] ew, er;
        ew = base + (32'(m_w) << (m_ll + 2)) + (32'(m_cnt) << 2);
        er = base + (32'(m_r) << (m_ll + 2));
        chk("model_write_address", wa, ew);
        chk("model_read_buffer", rb, er);
        chk("model_grant", 32'(grant), 32'(m_grant));
        chk("model_empty", 32'(empty), 32'(m_fifo.size() == 0));
        chk("model_frame_count", frame_cnt, m_frame);
        chk("model_drop_count", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic step(input logic r, input logic b, input logic q);
        rst = r; beat = b; req = q;
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    task automatic beats(input int n, input logic q);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, q);
    endtask

    typedef struct {
        logic        rst, beat, req;
        logic [31:0] wa, rb;
        logic        grant, empty;
        logic [31:0] frame;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int g;
        rst = 1'b1; beat = 1'b0; req = 1'b0; mode = 1'b0;
        log_len = 5'd2; base = 32'h1000_0000;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h1000_0010, 32'h1000_0000, 1'b0, 1'b1, 32'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h1000_0014, 32'h1000_0000, 1'b0, 1'b1, 32'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h1000_0018, 32'h1000_0000, 1'b0, 1'b1, 32'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h1000_001C, 32'h1000_0000, 1'b0, 1'b1, 32'd0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h1000_0020, 32'h1000_0000, 1'b0, 1'b0, 32'd1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h1000_0020, 32'h1000_0010, 1'b1, 1'b1, 32'd1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h1000_0020, 32'h1000_0010, 1'b0, 1'b1, 32'd1};

        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].rst, tbl[i].beat, tbl[i].req);
            chk($sformatf("tbl%0d_write_address", i), wa, tbl[i].wa);
            chk($sformatf("tbl%0d_read_buffer", i), rb, tbl[i].rb);
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
            chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].empty));
            chk($sformatf("tbl%0d_frame", i), frame_cnt, tbl[i].frame);
        end

        // latest mode: three frames then a claim
        mode = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        beats(12, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("latest_grant", 32'(grant), 32'd1);
        chk("latest_read_buffer", rb, 32'h1000_0010);
        chk("latest_drop", 32'(drop_cnt), 32'd2);
        chk("latest_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 1'b0);

        // queue mode: five frames, drop-oldest, claims oldest first
        mode = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        beats(20, 1'b0);
        chk("queue_drop", 32'(drop_cnt), 32'd3);
        chk("queue_not_empty", 32'(empty), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("queue_claim1_grant", 32'(grant), 32'd1);
        chk("queue_claim1_buffer", rb, 32'h1000_0010);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("queue_claim2_buffer", rb, 32'h1000_0020);
        chk("queue_claim2_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("queue_claim3_nogrant", 32'(grant), 32'd0);
        chk("queue_claim3_buffer", rb, 32'h1000_0020);
        step(1'b0, 1'b0, 1'b0);

        // claim edge coinciding with a frame completion, FIFO holding one entry
        step(1'b1, 1'b0, 1'b0);
        beats(7, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("simul_grant", 32'(grant), 32'd1);
        chk("simul_read_buffer", rb, 32'h1000_0010);
        chk("simul_write_address", wa, 32'h1000_0000);
        chk("simul_empty", 32'(empty), 32'd0);
        chk("simul_frame", frame_cnt, 32'd2);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("simul_next_claim", rb, 32'h1000_0020);
        step(1'b0, 1'b0, 1'b0);

        // claim on empty FIFO, then a request held high across two completions
        mode = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("empty_claim_grant", 32'(grant), 32'd0);
        chk("empty_claim_buffer", rb, 32'h1000_0000);
        step(1'b0, 1'b0, 1'b0);
        beats(4, 1'b0);
        g = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, i > 0, 1'b1);
            if (grant) g++;
        end
        chk("held_request_grants", 32'(g), 32'd1);
        chk("held_request_frames", frame_cnt, 32'd3);
        step(1'b0, 1'b0, 1'b0);

        // reset mid-frame
        step(1'b1, 1'b0, 1'b0);
        beats(2, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("midreset_write_address", wa, 32'h1000_0010);
        chk("midreset_read_buffer", rb, 32'h1000_0000);
        chk("midreset_frame", frame_cnt, 32'd0);
        chk("midreset_empty", 32'(empty), 32'd1);
        beats(3, 1'b0);
        chk("midreset_partial_frame", frame_cnt, 32'd0);
        beats(1, 1'b0);
        chk("midreset_full_frame", frame_cnt, 32'd1);

        // random traffic against the model
        begin
            logic rq;
            rq = 1'b0;
            step(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 3000; i++) begin
                log_len = 5'($urandom_range(0, 3));
                if ($urandom_range(0, 49) == 0) mode = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 5) == 0) rq = ~rq;
                if ($urandom_range(0, 399) == 0) begin
                    base = $urandom;
                    step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
                    rq = 1'b0;
                end else begin
                    step(1'b0, $urandom_range(0, 2) != 0, rq);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/buffer_ring_manager.md
# buffer_ring_manager

Parametrised N-buffer manager for the DMA capture path. A producer (S2MM writer) fills fixed-length frames in a ring of `BUFFER_COUNT` equal buffers in DDR, and a consumer (software via the register bank) claims completed frames. The block owns all buffer ownership bookkeeping and emits the producer's per-beat write address and the consumer's claimed-buffer address. It supports a latest-frame mode (triple buffering, generalised to N buffers) and an in-order queue mode with drop-oldest overflow.

## Interface
- `MM_ADDR_WIDTH`, 32: width of memory-mapped addresses.
- `DATA_WIDTH`, 32: beat width in bits; a power of two and at least 8.
- `BUFFER_COUNT`, 4: number of buffers; legal range 3..8.
- `IDX_WIDTH`, 3: buffer index width; must be at least clog2(`BUFFER_COUNT`).
- `SYS_aclk` in 1: the single clock.
- `SYS_areset` in 1: synchronous, active-high reset.
- `BRM_base_address` in `MM_ADDR_WIDTH`: start address of buffer 0.
- `BRM_log_length` in 5: log2 of the frame length in beats; legal range 0..22.
- `BRM_mode` in 1: 0 = latest, 1 = queue.
- `BRM_write_beat` in 1: the producer accepted one beat at `BRM_write_address` this cycle.
- `BRM_request` in 1: consumer claim, level; only its rising edge acts.
- `BRM_write_address` out `MM_ADDR_WIDTH`: address for the next producer beat.
- `BRM_read_buffer` out `MM_ADDR_WIDTH`: start address of the buffer currently claimed by the consumer.
- `BRM_grant` out 1: one-cycle pulse, asserted when a claim obtained a new frame.
- `BRM_empty` out 1: asserted when no completed frame is waiting.
- `BRM_frame_count` out 32: number of completed frames; wraps.
- `BRM_drop_count` out 16: number of completed frames discarded unread; saturates at 0xFFFF.

## Operation
- Each buffer is in exactly one state: FREE, WRITING, READY or READING.
- At most one buffer is WRITING and at most one is READING.
- READY buffers sit in an index FIFO of depth `BUFFER_COUNT`, ordered oldest first.
- Reset sets these values:
  - buffer 0 READING and buffer 1 WRITING; all others FREE.
  - FIFO empty; write count 0; both counters 0.
  - `BRM_grant` 0 and `BRM_empty` 1.
  - latched length taken from `BRM_log_length`.
- Latched length L = 1 << log_len. `log_len` is resampled from `BRM_log_length` only at reset and at each frame completion.
- Beat count: `BRM_write_beat` increments the write count. A beat arriving while the count is L-1 completes the frame and the count returns to 0.
- Frame completion (in the same cycle as the completing beat), in order:
  1. `BRM_frame_count` increments.
  2. In latest mode, every buffer in the FIFO is freed and `BRM_drop_count` increases by the number freed.
  3. The completed buffer is pushed to the FIFO as READY.
  4. The next write buffer is the lowest-index FREE buffer.
  5. If no buffer is FREE (queue mode only), the FIFO head is popped and becomes WRITING, and `BRM_drop_count` increments.
- Claim, on a rising edge of `BRM_request`, registered internally:
  - If the FIFO is non-empty, the head pops and becomes READING, the previous READING buffer becomes FREE, and `BRM_grant` pulses.
  - If the FIFO is empty, nothing changes and `BRM_grant` stays 0.
- Simultaneous claim and completion:
  - The claim is evaluated against the FIFO contents at the start of the cycle.
  - The buffer freed by the claim is eligible as the new write buffer in that same cycle.
  - If the FIFO holds exactly one entry, the claim pops it and the completed buffer is pushed; both happen.
- Address arithmetic is done in `MM_ADDR_WIDTH` bits and wraps modulo 2^`MM_ADDR_WIDTH`. With B = `DATA_WIDTH`/8:
  - `BRM_write_address` = base + (widx << (log_len + log2 B)) + (count << log2 B).
  - `BRM_read_buffer` = base + (ridx << (log_len + log2 B)).
- `BRM_mode` is sampled at each frame completion.

## Timing
- All outputs are registered.
- `BRM_write_address` reflects a beat on the next cycle. After a completing beat it points to the start of the new write buffer.
- `BRM_grant` pulses, and `BRM_read_buffer` updates, 1 cycle after the cycle in which the rising edge of `BRM_request` is sampled.
- A `BRM_request` held high yields exactly one claim; it must fall and rise again for another claim.
- `BRM_empty` and both counters update 1 cycle after the causing event.
- Reset asserted mid-frame discards all state; the partial frame is not counted.
- Changing `BRM_log_length` mid-frame does not affect the current frame.
- Beats that arrive while `SYS_areset` is high are ignored.

## Test plan
- Reset, log_len 2, base 0x1000_0000, B 4, latest mode → `BRM_write_address` 0x1000_0010, then 0x14, 0x18 and 0x1C on successive beats.
- Latest mode: 3 frames written, then a claim → `BRM_grant` pulses, `BRM_read_buffer` holds the third frame's buffer start, `BRM_drop_count` = 2, `BRM_empty` = 1.
- Queue mode, N=4: 5 frames written with no claims → `BRM_drop_count` = 3, FIFO holds the last 2 frames, and claims return them oldest first.
- Claim edge in the same cycle as a frame completion with the FIFO holding 1 entry → the old frame is granted, the completed frame is queued, and the next write buffer is the previous READING buffer when it is the lowest-index FREE.
- Claim with the FIFO empty → no `BRM_grant` and `BRM_read_buffer` unchanged. `BRM_request` held high across two completions → exactly one grant.
- Reset mid-frame after 2 beats → reset values restored, and `BRM_frame_count` stays 0 until L full beats have arrived.
